// File: rtl/ram_wb_adapter.sv
// rtl/ram_wb_adapter.sv - Wishbone classic slave in front of a single-port synchronous RAM.
// Byte-lane writes use read-modify-write because the RAM has no byte enables.
module ram_wb_adapter #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int MEMORY_DEPTH  = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [DATA_WIDTH/8-1:0] wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
  output logic [DATA_WIDTH-1:0]   wbs_dat_o,
  output logic                    wbs_ack_o,
  output logic                    ram_we_o,
  output logic [ADDRESS_WIDTH-1:0] ram_address_o,
  output logic [DATA_WIDTH-1:0]   ram_data_o,
  input  logic [DATA_WIDTH-1:0]   ram_data_i
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam logic [ADDRESS_WIDTH:0] DEPTH_W = MEMORY_DEPTH[ADDRESS_WIDTH:0];

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, RMW_RD, RMW_MERGE, WR, ACK
  } state_t;

  state_t                   state_q, state_d;
  logic                     ack_q, ack_d;
  logic [DATA_WIDTH-1:0]    rdat_q, rdat_d;
  logic                     ram_we_q, ram_we_d;
  logic [ADDRESS_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]    ram_wdat_q, ram_wdat_d;
  logic [DATA_WIDTH-1:0]    dat_q, dat_d;
  logic [SEL_WIDTH-1:0]     sel_q, sel_d;

  logic [ADDRESS_WIDTH-1:0] idx;
  logic                     in_range;
  logic [DATA_WIDTH-1:0]    merged;
  logic                     unused_adr_bits;

  assign idx             = wbs_adr_i[ADDRESS_WIDTH+1:2];
  assign in_range        = ({1'b0, idx} < DEPTH_W);
  assign unused_adr_bits = ^{wbs_adr_i[31:ADDRESS_WIDTH+2], wbs_adr_i[1:0]};

  always_comb begin
    merged = ram_data_i;
    for (int b = 0; b < SEL_WIDTH; b++) begin
      if (sel_q[b]) merged[8*b +: 8] = dat_q[8*b +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    ack_d      = 1'b0;
    rdat_d     = rdat_q;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_wdat_d = ram_wdat_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    case (state_q)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          dat_d = wbs_dat_i;
          sel_d = wbs_sel_i;
          if (!in_range) begin
            state_d = ACK;
            ack_d   = 1'b1;
            if (!wbs_we_i) rdat_d = '0;
          end else if (!wbs_we_i) begin
            ram_addr_d = idx;
            state_d    = RD_ADDR;
          end else if (wbs_sel_i == '0) begin
            state_d = ACK;
            ack_d   = 1'b1;
          end else if (&wbs_sel_i) begin
            ram_addr_d = idx;
            ram_wdat_d = wbs_dat_i;
            ram_we_d   = 1'b1;
            state_d    = WR;
          end else begin
            ram_addr_d = idx;
            state_d    = RMW_RD;
          end
        end
      end
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: begin
        // An aborted read neither acks nor disturbs the held read data.
        if (wbs_cyc_i) rdat_d = ram_data_i;
        ack_d   = wbs_cyc_i;
        state_d = ACK;
      end
      RMW_RD: state_d = RMW_MERGE;
      RMW_MERGE: begin
        ram_wdat_d = merged;
        ram_we_d   = 1'b1;
        state_d    = WR;
      end
      WR: begin
        ack_d   = wbs_cyc_i;
        state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ack_q      <= 1'b0;
      rdat_q     <= '0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_wdat_q <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      rdat_q     <= rdat_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_wdat_q <= ram_wdat_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
    end
  end

  assign wbs_ack_o     = ack_q;
  assign wbs_dat_o     = rdat_q;
  assign ram_we_o      = ram_we_q;
  assign ram_address_o = ram_addr_q;
  assign ram_data_o    = ram_wdat_q;

endmodule
